// File: rtl/key_operand_entry.sv
`default_nettype none
// ============================================================================
// key_operand_entry: synchronises and debounces KEY[3:0], emits press pulses,
// and maintains operand A (clear / load SW / increment / decrement).
// Revision: 1.0
// ============================================================================
module key_operand_entry #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] A,
  output logic             load,
  output logic [3:0]       key_level,
  output logic [3:0]       key_pressed
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_level;
  logic [3:0]       r_level_q;
  logic [3:0]       r_pressed;
  logic [3:0]       w_ksync;
  logic [3:0]       w_level_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] w_a_nxt;
  logic             r_load;
  logic             w_act;

  // Synchronisers reset to the released (high) level of the raw keys.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ksync = ~r_sync2;

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    assign w_differ        = w_ksync[gi] ^ r_level[gi];
    assign w_done          = w_differ && (r_cnt == c_LAST);
    assign w_level_nxt[gi] = w_done ? w_ksync[gi] : r_level[gi];

    // Any cycle of agreement restarts the stability count.
    always_ff @(posedge CLOCK_50) begin
      if (reset || !w_differ || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_level   <= 4'h0;
      r_level_q <= 4'h0;
      r_pressed <= 4'h0;
    end else begin
      r_level   <= w_level_nxt;
      r_level_q <= r_level;
      r_pressed <= r_level & ~r_level_q;
    end
  end

  // Priority KEY0 > KEY3 > KEY2 > KEY1; one action per cycle.
  always_comb begin
    w_a_nxt = r_a;
    w_act   = |r_pressed;
    if (r_pressed[0]) begin
      w_a_nxt = '0;
    end else if (r_pressed[3]) begin
      w_a_nxt = SW;
    end else if (r_pressed[2]) begin
      w_a_nxt = r_a + 1'b1;
    end else if (r_pressed[1]) begin
      w_a_nxt = r_a - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_a    <= '0;
      r_load <= 1'b0;
    end else begin
      r_a    <= w_a_nxt;
      r_load <= w_act;
    end
  end

  assign A           = r_a;
  assign load        = r_load;
  assign key_level   = r_level;
  assign key_pressed = r_pressed;

endmodule
`default_nettype wire
